// File: rtl/adder_feeder_if.sv
// Stream and adder-side signals of adder_feeder, bundled so the feeder and its
// environment connect through one port. The feeder uses slave and the environment uses master.
interface adder_feeder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_a_i;
    logic [WIDTH-1:0] in_b_i;

    logic [WIDTH-1:0] add_a_o;
    logic [WIDTH-1:0] add_b_o;
    logic [WIDTH-1:0] add_s_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_a_o;
    logic [WIDTH-1:0] out_b_o;
    logic [WIDTH-1:0] out_s_o;

    modport slave (
        input  in_valid_i, in_a_i, in_b_i, add_s_i, out_ready_i,
        output in_ready_o, add_a_o, add_b_o, out_valid_o, out_a_o, out_b_o, out_s_o
    );

    modport master (
        output in_valid_i, in_a_i, in_b_i, add_s_i, out_ready_i,
        input  in_ready_o, add_a_o, add_b_o, out_valid_o, out_a_o, out_b_o, out_s_o
    );
endinterface

// File: rtl/adder_feeder.sv
// Drives a combinational adder one operand pair at a time, captures its sum a cycle
// later into a fall-through FIFO, and flags any sum that disagrees with a local reference.
module adder_feeder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    adder_feeder_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]       r_state;
    logic             r_live;
    logic [WIDTH-1:0] r_addA;
    logic [WIDTH-1:0] r_addB;
    logic             r_err;
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_memA [DEPTH];
    logic [WIDTH-1:0] r_memB [DEPTH];
    logic [WIDTH-1:0] r_memS [DEPTH];

    logic             w_inReady;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_outValid;
    logic [WIDTH-1:0] w_refSum;

    // r_live keeps in_ready_o low until the first edge after reset is released.
    assign w_inReady  = r_live && (r_state == ST_IDLE) && (r_count < FULL);
    assign w_accept   = bus.in_valid_i && w_inReady;
    assign w_push     = (r_state == ST_DRIVE);
    assign w_outValid = (r_count != '0);
    assign w_pop      = w_outValid && bus.out_ready_i;
    assign w_refSum   = r_addA + r_addB;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_live  <= 1'b0;
            r_state <= ST_IDLE;
            r_addA  <= '0;
            r_addB  <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addA  <= bus.in_a_i;
                        r_addB  <= bus.in_b_i;
                        r_state <= ST_DRIVE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Carry-out is intentionally dropped from the reference, so wraparound is not an error.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_push && (bus.add_s_i != w_refSum)) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_memA[r_wrPtr] <= r_addA;
            r_memB[r_wrPtr] <= r_addB;
            r_memS[r_wrPtr] <= bus.add_s_i;
        end
    end

    assign bus.in_ready_o  = w_inReady;
    assign bus.add_a_o     = r_addA;
    assign bus.add_b_o     = r_addB;
    assign bus.out_valid_o = w_outValid;
    assign bus.out_a_o     = w_outValid ? r_memA[r_rdPtr] : '0;
    assign bus.out_b_o     = w_outValid ? r_memB[r_rdPtr] : '0;
    assign bus.out_s_o     = w_outValid ? r_memS[r_rdPtr] : '0;

    assign count_o = r_count;
    assign busy_o  = (r_state == ST_DRIVE);
    assign err_o   = r_err;

endmodule
